// File: rtl/i2c_slave_mem.sv
// ============================================================================
// i2c_slave_mem
// ----------------------------------------------------------------------------
// I2C slave with a small byte-wide register memory. The master writes a
// pointer byte after the address, then data bytes are stored at the pointer
// (auto-increment, wrapping). A read continues from the current pointer.
// The pointer survives STOP and repeated START.
//
// Optional feature (define the macro to enable):
//   I2C_SLAVE_GLITCH_FILTER_EN - 3-sample majority filter after the
//                                synchroniser on SCL and SDA (+2 cycles of
//                                latency, rejects 1-cycle pulses).
//
// Ports:
//   i2c_core_clk_i  core clock, everything runs on its rising edge
//   i2c_core_rst_i  synchronous active-high reset
//   scl_i, sda_i    raw bus line levels (asynchronous)
//   sda_oe_o        1 = pull SDA low, 0 = release
//   busy_o          high from an address-matched START until STOP / abandon
//   wr_valid_o      one-cycle pulse per byte written to memory
//   wr_ptr_o        location written, valid with wr_valid_o
//   wr_data_o       byte written, valid with wr_valid_o
//   stop_o          one-cycle pulse on each detected STOP
//   dbg_addr_i      back-door read address
//   dbg_data_o      mem[dbg_addr_i], combinational
// ============================================================================
module i2c_slave_mem #(
    parameter logic [6:0] SLAVE_ADDR = 7'h25,
    parameter int         MEM_DEPTH  = 16,
    parameter int         PTR_W      = 4
) (
    input  logic             i2c_core_clk_i,
    input  logic             i2c_core_rst_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe_o,
    output logic             busy_o,
    output logic             wr_valid_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [7:0]       wr_data_o,
    output logic             stop_o,
    input  logic [PTR_W-1:0] dbg_addr_i,
    output logic [7:0]       dbg_data_o
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic [6:0]       rd_shift;
    logic             rw;
    logic [7:0]       mem [MEM_DEPTH];

    logic [1:0] scl_sync, sda_sync;
    logic       scl_line, sda_line;
    logic       scl_prev, sda_prev;
    logic       scl_rise, scl_fall, start_det, stop_det;

    // Two-flop synchronisers. Reset to 1 (idle bus) so that leaving reset
    // never looks like an SDA/SCL falling edge.
    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_filt, sda_filt;

    // Majority of the current synchronised sample and the two before it.
    // A level must be present for two consecutive samples to pass, so a
    // 1-cycle pulse is dropped and every real edge arrives 2 cycles later.
    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_filt <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) |
                        (scl_hist[0] & scl_hist[1]);
            sda_filt <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) |
                        (sda_hist[0] & sda_hist[1]);
        end
    end

    assign scl_line = scl_filt;
    assign sda_line = sda_filt;
`else
    assign scl_line = scl_sync[1];
    assign sda_line = sda_sync[1];
`endif

    // Previous line levels for edge detection.
    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_line;
            sda_prev <= sda_line;
        end
    end

    // START/STOP require SCL high both before and after the SDA change.
    assign scl_rise  =  scl_line & ~scl_prev;
    assign scl_fall  = ~scl_line &  scl_prev;
    assign start_det =  scl_line & scl_prev &  sda_prev & ~sda_line;
    assign stop_det  =  scl_line & scl_prev & ~sda_prev &  sda_line;

    assign dbg_data_o = mem[dbg_addr_i];

    // Protocol FSM. Bits are sampled on detected SCL rising edges; SDA is
    // changed only one cycle after a detected SCL falling edge, so our own
    // drive never changes while the master sees SCL high. bit_cnt counts
    // sampled bits of the current byte; reaching 8 marks the byte complete
    // and the following falling edge opens the ACK slot.
    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            state      <= IDLE;
            ptr        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            rd_shift   <= '0;
            rw         <= 1'b0;
            sda_oe_o   <= 1'b0;
            busy_o     <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_ptr_o   <= '0;
            wr_data_o  <= '0;
            stop_o     <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            wr_valid_o <= 1'b0;
            stop_o     <= 1'b0;
            if (stop_det) begin
                state    <= IDLE;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
                bit_cnt  <= '0;
                stop_o   <= 1'b1;
            end else if (start_det) begin
                // busy_o is left alone so a repeated START keeps the
                // transaction busy; the address phase decides again.
                state    <= ADDR;
                sda_oe_o <= 1'b0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_line};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (shift[7:1] == SLAVE_ADDR) begin
                                state    <= ADDR_ACK;
                                sda_oe_o <= 1'b1;
                                busy_o   <= 1'b1;
                                rw       <= shift[0];
                            end else begin
                                state  <= WAIT_STOP;
                                busy_o <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                // First read bit goes out as the ACK slot ends.
                                state    <= RD_DATA;
                                rd_shift <= mem[ptr][6:0];
                                sda_oe_o <= ~mem[ptr][7];
                            end else begin
                                state    <= PTR;
                                sda_oe_o <= 1'b0;
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_line};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            ptr      <= shift[PTR_W-1:0];
                            bit_cnt  <= '0;
                            state    <= PTR_ACK;
                            sda_oe_o <= 1'b1;
                        end
                    end
                    PTR_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            state    <= WR_DATA;
                            sda_oe_o <= 1'b0;
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_line};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                mem[ptr]   <= {shift[6:0], sda_line};
                                wr_valid_o <= 1'b1;
                                wr_ptr_o   <= ptr;
                                wr_data_o  <= {shift[6:0], sda_line};
                                ptr        <= ptr + PTR_W'(1);
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt  <= '0;
                            state    <= WR_ACK;
                            sda_oe_o <= 1'b1;
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt  <= '0;
                                state    <= RD_ACK;
                                sda_oe_o <= 1'b0;
                                ptr      <= ptr + PTR_W'(1);
                            end else begin
                                sda_oe_o <= ~rd_shift[6];
                                rd_shift <= {rd_shift[5:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: begin
                        // The rising edge always precedes the falling edge
                        // here, so reaching the fall means the master ACKed.
                        if (scl_rise && sda_line) begin
                            state <= WAIT_STOP;
                        end else if (scl_fall) begin
                            state    <= RD_DATA;
                            rd_shift <= mem[ptr][6:0];
                            sda_oe_o <= ~mem[ptr][7];
                        end
                    end
                    IDLE, WAIT_STOP: begin
                        sda_oe_o <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        sda_oe_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_mem.sv
// ============================================================================
// tb_i2c_slave_mem
// ----------------------------------------------------------------------------
// Directed bench for i2c_slave_mem: a bit-banged I2C master drives SCL/SDA
// (SDA is wired-AND with the slave's open-drain pull), a monitor logs write
// pulses and STOP pulses, and every comparison is an immediate assertion.
// ============================================================================
module tb_i2c_slave_mem;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_bus;
    logic       sda_oe, busy, wr_valid, stop_p;
    logic [3:0] wr_ptr, dbg_addr;
    logic [7:0] wr_data, dbg_data;

    int errors = 0;
    int checks = 0;

    int         wr_cnt = 0;
    int         stop_cnt = 0;
    int         oe_cnt = 0;
    int         busy_cnt = 0;
    logic [3:0] log_ptr [32];
    logic [7:0] log_data [32];

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_mem #(
        .SLAVE_ADDR(7'h25),
        .MEM_DEPTH (16),
        .PTR_W     (4)
    ) dut (
        .i2c_core_clk_i(clk),
        .i2c_core_rst_i(rst),
        .scl_i         (scl_m),
        .sda_i         (sda_bus),
        .sda_oe_o      (sda_oe),
        .busy_o        (busy),
        .wr_valid_o    (wr_valid),
        .wr_ptr_o      (wr_ptr),
        .wr_data_o     (wr_data),
        .stop_o        (stop_p),
        .dbg_addr_i    (dbg_addr),
        .dbg_data_o    (dbg_data)
    );

    // Monitor: sampled on the falling clock edge, away from DUT updates.
    always @(negedge clk) begin
        if (wr_valid) begin
            if (wr_cnt < 32) begin
                log_ptr[wr_cnt]  = wr_ptr;
                log_data[wr_cnt] = wr_data;
            end
            wr_cnt++;
        end
        if (stop_p) stop_cnt++;
        if (sda_oe) oe_cnt++;
        if (busy)   busy_cnt++;
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_mem(input logic [3:0] a, input logic [7:0] expected);
        dbg_addr = a;
        #1;
        check_output($sformatf("mem[%0d]", a), {24'd0, dbg_data}, {24'd0, expected});
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1;
            wait_q();
            scl_m = 1'b1;
        end
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        b = sda_bus;
        wait_q();
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        acked = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic give_ack);
        logic b;
        logic [7:0] tmp;
        tmp = '0;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            tmp[i] = b;
        end
        write_bit(~give_ack);
        d = tmp;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         snap_stop, snap_wr, snap_oe, snap_busy;

        rst      = 1'b1;
        scl_m    = 1'b1;
        sda_m    = 1'b1;
        dbg_addr = 4'd0;
        repeat (4) @(negedge clk);

        // Reset state
        check_output("rst_sda_oe",   {31'd0, sda_oe},   32'd0);
        check_output("rst_busy",     {31'd0, busy},     32'd0);
        check_output("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check_output("rst_stop",     {31'd0, stop_p},   32'd0);
        check_output("rst_wr_ptr",   {28'd0, wr_ptr},   32'd0);
        check_output("rst_wr_data",  {24'd0, wr_data},  32'd0);
        check_mem(4'd7, 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write 8A 2B C3 starting at pointer 3
        $display("[TB] write transaction");
        snap_stop = stop_cnt;
        i2c_start();
        write_byte(8'h4A, ack); check_output("wr_addr_ack", {31'd0, ack}, 32'd1);
        check_output("wr_busy", {31'd0, busy}, 32'd1);
        write_byte(8'h03, ack); check_output("wr_ptr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h8A, ack); check_output("wr_d0_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h2B, ack); check_output("wr_d1_ack", {31'd0, ack}, 32'd1);
        write_byte(8'hC3, ack); check_output("wr_d2_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check_output("wr_count", wr_cnt, 32'd3);
        check_output("wr_log0_ptr",  {28'd0, log_ptr[0]},  32'd3);
        check_output("wr_log0_data", {24'd0, log_data[0]}, 32'h8A);
        check_output("wr_log1_ptr",  {28'd0, log_ptr[1]},  32'd4);
        check_output("wr_log1_data", {24'd0, log_data[1]}, 32'h2B);
        check_output("wr_log2_ptr",  {28'd0, log_ptr[2]},  32'd5);
        check_output("wr_log2_data", {24'd0, log_data[2]}, 32'hC3);
        check_output("wr_stop_pulses", stop_cnt - snap_stop, 32'd1);
        check_output("wr_busy_after_stop", {31'd0, busy}, 32'd0);
        check_mem(4'd3, 8'h8A);
        check_mem(4'd4, 8'h2B);
        check_mem(4'd5, 8'hC3);

        // Read back through a repeated START
        $display("[TB] read transaction");
        i2c_start();
        write_byte(8'h4A, ack); check_output("rd_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h03, ack); check_output("rd_ptr_ack", {31'd0, ack}, 32'd1);
        i2c_start();
        write_byte(8'h4B, ack); check_output("rd_addr2_ack", {31'd0, ack}, 32'd1);
        read_byte(rd, 1'b1); check_output("rd_byte0", {24'd0, rd}, 32'h8A);
        check_output("rd_busy_mid", {31'd0, busy}, 32'd1);
        read_byte(rd, 1'b1); check_output("rd_byte1", {24'd0, rd}, 32'h2B);
        read_byte(rd, 1'b0); check_output("rd_byte2", {24'd0, rd}, 32'hC3);
        check_output("rd_busy_before_stop", {31'd0, busy}, 32'd1);
        i2c_stop();
        check_output("rd_busy_after_stop", {31'd0, busy}, 32'd0);

        // Pointer wrap on write
        $display("[TB] wrap");
        i2c_start();
        write_byte(8'h4A, ack);
        write_byte(8'h0F, ack);
        write_byte(8'h94, ack); check_output("wrap_d0_ack", {31'd0, ack}, 32'd1);
        write_byte(8'hC5, ack); check_output("wrap_d1_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check_output("wrap_count", wr_cnt, 32'd5);
        check_output("wrap_log3_ptr", {28'd0, log_ptr[3]}, 32'd15);
        check_output("wrap_log4_ptr", {28'd0, log_ptr[4]}, 32'd0);
        check_mem(4'd15, 8'h94);
        check_mem(4'd0, 8'hC5);

        // START immediately followed by STOP
        $display("[TB] start-stop");
        snap_stop = stop_cnt;
        i2c_start();
        i2c_stop();
        check_output("ss_stop_pulses", stop_cnt - snap_stop, 32'd1);
        check_output("ss_busy", {31'd0, busy}, 32'd0);
        check_output("ss_no_write", wr_cnt, 32'd5);
        check_mem(4'd0, 8'hC5);

        // Address mismatch: nothing driven, nothing written
        $display("[TB] address mismatch");
        snap_wr   = wr_cnt;
        snap_oe   = oe_cnt;
        snap_busy = busy_cnt;
        i2c_start();
        write_byte(8'h68, ack); check_output("mm_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h55, ack); check_output("mm_data_ack", {31'd0, ack}, 32'd0);
        check_output("mm_oe_cycles", oe_cnt - snap_oe, 32'd0);
        check_output("mm_busy_cycles", busy_cnt - snap_busy, 32'd0);
        check_output("mm_no_write", wr_cnt - snap_wr, 32'd0);
        i2c_stop();
        check_mem(4'd3, 8'h8A);

        // Reset during bit 4 of a read of 0x8A (bit 4 is 0, so SDA is pulled)
        $display("[TB] reset mid-read");
        i2c_start();
        write_byte(8'h4A, ack);
        write_byte(8'h03, ack);
        i2c_stop();
        i2c_start();
        write_byte(8'h4B, ack); check_output("rr_addr_ack", {31'd0, ack}, 32'd1);
        for (int i = 0; i < 3; i++) read_bit(ack);
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        check_output("rr_oe_bit4", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("rr_oe_after_rst", {31'd0, sda_oe}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        scl_m = 1'b0;
        wait_q();
        i2c_stop();
        i2c_start();
        write_byte(8'h4B, ack); check_output("rr2_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(rd, 1'b0); check_output("rr2_byte", {24'd0, rd}, 32'h00);
        i2c_stop();
        check_mem(4'd3, 8'h00);
        check_mem(4'd15, 8'h00);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // One-cycle SDA low glitch with SCL high must not start a transfer
        $display("[TB] glitch filter");
        @(negedge clk);
        sda_m = 1'b0;
        @(negedge clk);
        sda_m = 1'b1;
        repeat (10) @(negedge clk);
        scl_m = 1'b0;
        wait_q();
        write_byte(8'h4A, ack); check_output("gf_no_ack", {31'd0, ack}, 32'd0);
        check_output("gf_busy", {31'd0, busy}, 32'd0);
        i2c_stop();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_mem.md
I2C_SLAVE_MEM -- requirements
Module: i2c_slave_mem

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h25, is the 7-bit I2C address the block responds to.
REQ-002 Parameter MEM_DEPTH, default 16, is the number of byte locations; power of two, 2..256.
REQ-003 Parameter PTR_W, default 4, is the pointer width; SHALL equal log2(MEM_DEPTH).
REQ-004 i2c_core_clk_i  in  1  core clock; all logic on its rising edge.
REQ-005 i2c_core_rst_i  in  1  reset, synchronous, active-high.
REQ-006 scl_i  in  1  raw SCL line level, asynchronous to the clock.
REQ-007 sda_i  in  1  raw SDA line level, asynchronous to the clock.
REQ-008 sda_oe_o  out  1  1 = pull SDA low (open drain); 0 = release.
REQ-009 busy_o  out  1  high from an address-matched START until STOP or abandon.
REQ-010 wr_valid_o  out  1  one-cycle pulse per data byte written to memory.
REQ-011 wr_ptr_o  out  PTR_W  location written; valid with wr_valid_o.
REQ-012 wr_data_o  out  8  byte written; valid with wr_valid_o.
REQ-013 stop_o  out  1  one-cycle pulse on each detected STOP.
REQ-014 dbg_addr_i  in  PTR_W  back-door read address.
REQ-015 dbg_data_o  out  8  mem[dbg_addr_i], combinational.

Function
REQ-016 scl_i and sda_i SHALL pass through a 2-flop synchroniser; edges are detected on the synchronised values.
REQ-017 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both SHALL be honoured in every state.
REQ-018 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-019 START from any state -> ADDR, bit counter cleared (repeated START supported); STOP from any state -> IDLE, sda_oe_o = 0.
REQ-020 ADDR: 8 bits shifted MSB first on SCL rising; address match with R/W=0 -> ADDR_ACK, then PTR; match with R/W=1 -> ADDR_ACK, then RD_DATA; mismatch -> WAIT_STOP with no ACK.
REQ-021 ACK: sda_oe_o SHALL assert one clock after the SCL falling edge ending bit 8 and release one clock after the next SCL falling edge.
REQ-022 PTR: received byte[PTR_W-1:0] loads the pointer; upper bits ignored; ACK -> WR_DATA.
REQ-023 WR_DATA: each byte is written to mem[ptr], wr_valid_o pulses in the cycle bit 8 is sampled, byte is ACKed, ptr increments.
REQ-024 RD_DATA: mem[ptr] is latched at entry; each bit drives sda_oe_o = ~bit one clock after SCL falling; ptr increments after bit 8.
REQ-025 RD_ACK: SDA released; master ACK (0) sampled on SCL rising -> RD_DATA; NACK (1) -> WAIT_STOP.
REQ-026 Pointer SHALL wrap from MEM_DEPTH-1 to 0 on read and write.
REQ-027 Pointer SHALL persist across STOP and repeated START; a read without a preceding pointer write continues from the current pointer.
REQ-028 A START followed immediately by a STOP (no bits) SHALL return to IDLE with no memory change.
REQ-029 Core clock SHALL be at least 8x the SCL frequency; no clock stretching.

Reset
REQ-030 On i2c_core_rst_i: state IDLE, pointer 0, bit counter 0, sda_oe_o 0, busy_o 0, wr_valid_o 0, stop_o 0, wr_ptr_o 0, wr_data_o 0.
REQ-031 Memory contents SHALL reset to 0.
REQ-032 Reset asserted mid-transfer SHALL release SDA in the cycle after reset is sampled; the block then waits for a fresh START.

Configuration
REQ-033 Macro I2C_SLAVE_GLITCH_FILTER_EN defined: a 3-sample majority filter follows the synchroniser on both lines, adding 2 cycles of latency to every edge; pulses of 1 cycle are rejected.
REQ-034 Macro undefined: no filter; edge detection directly on synchroniser outputs; all other behaviour identical.

Verification
REQ-035 Write: START, 0x4A, ptr 0x03, data 0x8A 0x2B 0xC3, STOP -> 5 ACKs, mem[3..5] = 8A 2B C3, three wr_valid_o pulses, one stop_o pulse.
REQ-036 Read: START, 0x4A, ptr 0x03, repeated START, 0x4B, master ACK, ACK, NACK -> SDA bytes 8A 2B C3, busy_o until STOP.
REQ-037 Wrap: ptr 0x0F, write 0x94 0xC5 -> mem[15] = 94, mem[0] = C5, wr_ptr_o sequence 15 then 0.
REQ-038 Mismatch: START, 0x68 -> SDA never driven, busy_o stays 0, memory unchanged until the next STOP.
REQ-039 Reset mid-read during bit 4 -> sda_oe_o 0 next cycle; a subsequent read at ptr 0 returns 0x00.
REQ-040 With I2C_SLAVE_GLITCH_FILTER_EN: a 1-cycle SDA low glitch while SCL high -> no START detected, state unchanged.
